// File: rtl/countdown8.sv
// countdown8: loadable prescaled down-counter with done pulse, expiry and optional auto-reload
module countdown8 #(
  parameter int WIDTH = 8,
  parameter int DIV = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             expired,
  output logic             running
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] p, p_n, q_n;
  logic [PW-1:0] pre, pre_n;
  logic done_n;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      q <= '0;
      p <= '0;
      pre <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      q <= q_n;
      p <= p_n;
      pre <= pre_n;
      done <= done_n;
    end
  always_comb begin
    state_n = state;
    q_n = q;
    p_n = p;
    pre_n = pre;
    done_n = 1'b0;
    if (load) begin
      q_n = d;
      p_n = d;
      pre_n = '0;
      state_n = IDLE;
    end else
      case (state)
        IDLE: state_n = (enable && q != '0) ? RUN : IDLE;
        RUN:
          if (!enable) state_n = PAUSED;
          else if (pre != TOP) pre_n = pre + 1'b1;
          else begin
            pre_n = '0;
            if (q != WIDTH'(1)) q_n = q - 1'b1;
            else begin
              // reaching zero by counting is the only source of done
              done_n = 1'b1;
              q_n = AUTO_RELOAD ? p : '0;
              state_n = !AUTO_RELOAD ? EXPIRED : (p == '0 ? IDLE : RUN);
            end
          end
        PAUSED: state_n = enable ? RUN : PAUSED;
        EXPIRED: state_n = EXPIRED;
      endcase
  end
  assign expired = state == EXPIRED;
  assign running = state == RUN;
endmodule

// File: tb/tb_countdown8.sv
// tb_countdown8: directed checks of countdown8 in DIV=1, DIV=4 and auto-reload builds
module tb_countdown8;
  logic clock = 1'b0, reset, load, enable;
  logic [7:0] d, q1, q4, qa;
  logic done1, exp1, run1, done4, exp4, run4, donea, expa, runa;
  int tests = 0, fails = 0;

  countdown8 #(.WIDTH(8), .DIV(1), .AUTO_RELOAD(1'b0)) u1 (.clock(clock), .reset(reset), .load(load),
    .enable(enable), .d(d), .q(q1), .done(done1), .expired(exp1), .running(run1));
  countdown8 #(.WIDTH(8), .DIV(4), .AUTO_RELOAD(1'b0)) u4 (.clock(clock), .reset(reset), .load(load),
    .enable(enable), .d(d), .q(q4), .done(done4), .expired(exp4), .running(run4));
  countdown8 #(.WIDTH(8), .DIV(1), .AUTO_RELOAD(1'b1)) ua (.clock(clock), .reset(reset), .load(load),
    .enable(enable), .d(d), .q(qa), .done(donea), .expired(expa), .running(runa));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    d = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load = 1'($urandom);
    enable = 1'($urandom);
    d = 8'($urandom);
    #22 reset = 1'b0;
    #1;
    chk("rst_q", q1, 0);
    chk("rst_done", done1, 0);
    chk("rst_exp", exp1, 0);
    chk("rst_run", run1, 0);
    load = 1'b0;
    enable = 1'b1;
    tick(3);
    chk("rst_hold_q", q1, 0);
    chk("rst_hold_run", run1, 0);

    enable = 1'b0;
    do_load(8'h05);
    chk("t2_load_q", q1, 8'h05);
    enable = 1'b1;
    tick();
    chk("t2_run", run1, 1);
    chk("t2_no_dec", q1, 8'h05);
    for (int v = 4; v >= 1; v--) begin
      tick();
      chk("t2_q", q1, v);
      chk("t2_done_lo", done1, 0);
    end
    tick();
    chk("t2_q0", q1, 0);
    chk("t2_done", done1, 1);
    chk("t2_exp", exp1, 1);
    chk("t2_run_off", run1, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_hold_q", q1, 0);
      chk("t2_hold_done", done1, 0);
      chk("t2_hold_exp", exp1, 1);
    end

    enable = 1'b0;
    do_load(8'h03);
    chk("t3_exp_clr", exp4, 0);
    enable = 1'b1;
    tick();
    chk("t3_run", run4, 1);
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk("t3_q", q4, 3 - n / 4);
      chk("t3_done", done4, n == 12);
      if (n == 2) begin
        enable = 1'b0;
        tick(3);
        chk("t3_paused", run4, 0);
        chk("t3_pause_q", q4, 3);
        enable = 1'b1;
        tick();
        chk("t3_resume", run4, 1);
        chk("t3_resume_q", q4, 3);
      end
    end
    chk("t3_exp", exp4, 1);

    enable = 1'b0;
    do_load(8'h00);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_q", q1, 0);
      chk("t4_run", run1, 0);
      chk("t4_done", done1, 0);
    end

    enable = 1'b0;
    do_load(8'h02);
    enable = 1'b1;
    tick();
    chk("t5_q", qa, 2);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t5_q", qa, i % 2 ? 1 : 2);
      chk("t5_done", donea, i % 2 == 0);
      chk("t5_exp", expa, 0);
      chk("t5_run", runa, 1);
    end

    enable = 1'b0;
    do_load(8'h20);
    enable = 1'b1;
    tick(3);
    chk("t6_q1", q1, 8'h1e);
    load = 1'b1;
    d = 8'hff;
    tick();
    load = 1'b0;
    chk("t6_ld_q", q1, 8'hff);
    chk("t6_ld_run", run1, 0);
    chk("t6_ld_q4", q4, 8'hff);
    tick();
    chk("t6_rerun", run1, 1);
    tick(3);
    chk("t6_pre_clr", q4, 8'hff);
    tick();
    chk("t6_pre_tick", q4, 8'hfe);

    enable = 1'b0;
    do_load(8'h01);
    enable = 1'b1;
    tick(2);
    chk("t6_expired", exp1, 1);
    do_load(8'h10);
    chk("t6_exp_clr", exp1, 0);
    chk("t6_exp_q", q1, 8'h10);
    tick(2);
    chk("t6_restart", q1, 8'h0f);

    reset = 1'b1;
    #2;
    chk("arst_q1", q1, 0);
    chk("arst_q4", q4, 0);
    chk("arst_run", run1, 0);
    chk("arst_qa", qa, 0);
    #10 reset = 1'b0;
    tick(2);
    chk("arst_hold", q1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/countdown8.md
Name: countdown8

Overview:
Loadable down-counter with a tick prescaler and terminal-count signalling. It counts a preset value down to zero and flags expiry, making it the decrementing counterpart of the board's 8-bit enable/reset up-counter. It sits between switch/key inputs and the hex/LED display path. Q drives LEDR and the two hex digit decoders, and Done/Expired drive status LEDs.

Parameters:
WIDTH, 8, counter and preset width in bits.
DIV, 1, number of enabled clock cycles per decrement (1 = decrement every enabled cycle); legal range 1..2^16.
AUTO_RELOAD, 0, 1 = on expiry reload the last loaded preset and keep running; 0 = stop at zero.

Ports:
Clock  input  1  rising-edge clock (KEY-driven or 50 MHz).
Reset  input  1  asynchronous, active-high reset.
Load  input  1  synchronous load of D into Q.
Enable  input  1  level enable; counting advances only while high.
D  input  WIDTH  preset value.
Q  output  WIDTH  current count, registered.
Done  output  1  one-cycle pulse on the cycle Q becomes 0 by counting.
Expired  output  1  level, high while in EXPIRED.
Running  output  1  level, high while in RUN.

Behaviour:
- One clock: Clock. Reset is asynchronous and active-high; no other async inputs.
- Reset values: Q=0, Done=0, Expired=0, Running=0, state=IDLE, prescaler=0, preset register P=0.
- State machine: IDLE, RUN, PAUSED, EXPIRED. Encoding is free, but all outputs are registered or decoded from registered state.
- Load has priority over everything except Reset, in every state.
  - Effects: Q<=D, P<=D, prescaler<=0, Done<=0, state<=IDLE.
  - Enable on the same cycle is ignored.
- IDLE:
  - Enable=1 and Q!=0 -> RUN next cycle. No decrement on the transition cycle.
  - Enable=1 and Q==0 -> stay IDLE; Done is never asserted.
- RUN, Enable=1, each cycle:
  - If prescaler==DIV-1: prescaler<=0 and Q<=Q-1 (a "tick").
  - Otherwise: prescaler<=prescaler+1.
- RUN, expiry (tick with Q==1):
  - Q<=0, Done<=1 for exactly one cycle.
  - AUTO_RELOAD=0: state<=EXPIRED.
  - AUTO_RELOAD=1: Q<=P instead of 0; Done still pulses; state stays RUN. If P==0 (not possible from RUN), go to IDLE.
- RUN, Enable=0 -> PAUSED. Prescaler and Q are held, with no tick that cycle.
- PAUSED: Enable=1 -> RUN. The prescaler resumes from its held value, so pausing does not lose partial periods.
- EXPIRED: Q holds 0 and Expired=1. Enable has no effect. Only Load or Reset leaves this state.
- Latency:
  - The first decrement occurs DIV enabled cycles after entering RUN.
  - Total enabled RUN cycles from load value N to Done = N*DIV.
- Q never wraps below 0. Decrement is modulo-free and saturates by construction, since expiry stops it.
- Reset mid-count (any state, any prescaler value) clears everything immediately, without waiting for a clock edge.
- Done and Expired: Done is asserted on the same edge that sets Q=0 or reloads. In AUTO_RELOAD=0 mode, Expired rises on that same edge.

Test Plan:
1. Reset=1 with random D/Load/Enable, released mid-cycle -> Q=0, Done=0, Expired=0, Running=0 immediately, and hold until the next Load.
2. DIV=1: Load D=8'h05, then Enable=1 held -> Running the next cycle; Q steps 5,4,3,2,1,0 on consecutive cycles. Done pulses exactly once with Q=0, then Expired=1 and Q stays 0 for 20 more cycles.
3. DIV=4: Load 8'h03, Enable=1 with Enable=0 for 3 cycles mid-period -> Q decrements every 4 enabled cycles. Done arrives after exactly 12 enabled RUN cycles, with no lost prescaler count across the pause.
4. Load 8'h00, Enable=1 for 10 cycles -> stays IDLE; Q=0, Done never asserts, Running=0.
5. AUTO_RELOAD=1, DIV=1: Load 8'h02, Enable=1 -> Q sequence 2,1,2,1,2 and so on. Done pulses on every reload; Expired stays 0.
6. Load=1 asserted during RUN with D=8'hFF and Enable=1 -> Q=FF and state IDLE the next cycle, prescaler cleared. Load during EXPIRED with D=8'h10 clears Expired and restarts cleanly.
